// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the SHAKE128 absorb controller.
package keccak_pkg;

    localparam int unsigned DATA_SIZE  = 64;
    localparam int unsigned RATE_WORDS = 21;
    localparam int unsigned WC_W       = 5;
    localparam logic [7:0]  DOMAIN     = 8'h1F;
    localparam logic [7:0]  PAD_END    = 8'h80;

    typedef enum logic [2:0] {
        ST_ABSORB,
        ST_PAD,
        ST_PSTART,
        ST_PWAIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/keccak_pad_word.sv
// Combinational pad10*1 word former: masks the final message word, inserts the
// domain byte and the closing 0x80 end marker.
module keccak_pad_word
    import keccak_pkg::*;
(
    input  logic [DATA_SIZE-1:0] data,
    input  logic [3:0]           nbytes,
    input  logic                 last,
    input  logic                 ds_in,
    input  logic                 is_final,
    output logic [DATA_SIZE-1:0] word,
    output logic                 ds_pend
);

    logic [3:0] nb;

    always_comb begin
        nb      = (nbytes > 4'd8) ? 4'd8 : nbytes;
        word    = data;
        ds_pend = 1'b0;
        if (last) begin
            for (int unsigned k = 0; k < DATA_SIZE / 8; k++) begin
                if (k > 32'(nb))
                    word[8*k +: 8] = '0;
                else if (k == 32'(nb))
                    word[8*k +: 8] = DOMAIN;
            end
            // a full final word leaves no room for the domain byte
            ds_pend = (nb == 4'd8);
        end else if (ds_in) begin
            word[7:0] = word[7:0] | DOMAIN;
        end
        if (is_final && !(last && nb == 4'd8))
            word[DATA_SIZE-1 -: 8] = word[DATA_SIZE-1 -: 8] | PAD_END;
    end

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// Absorb sequencer for the rate shift register and Keccak-f core.
// Optional KECCAK_BLKCNT_EN adds a 16-bit permutation block counter output.
module keccak_absorb_ctrl
    import keccak_pkg::*;
(
    input  logic                 clk,
    input  logic                 hash_init,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_SIZE-1:0] in_data,
    input  logic                 in_last,
    input  logic [3:0]           in_nbytes,
    output logic [DATA_SIZE-1:0] sipo_data,
    output logic                 sipo_load_en,
    output logic                 sipo_last,
    output logic                 perm_start,
    input  logic                 perm_done,
    output logic                 msg_done
`ifdef KECCAK_BLKCNT_EN
    ,
    output logic [15:0]          blk_cnt
`endif
);

    state_t               state_q, state_d;
    logic [WC_W-1:0]      wc_q, wc_d;
    logic                 ds_pend_q, ds_pend_d;
    logic                 msg_end_q, msg_end_d;
    logic [DATA_SIZE-1:0] sipo_data_d;
    logic                 load_d, last_d, ps_d, done_d;

    logic                 wc_final;
    logic [DATA_SIZE-1:0] pw_data, pw_word;
    logic                 pw_last, pw_final, pw_ds;

    assign in_ready = (state_q == ST_ABSORB);
    assign wc_final = (wc_q == WC_W'(RATE_WORDS - 1));

    // PAD reuses the word former with a zero word; the end marker only applies
    // when this word closes the message's padding.
    assign pw_data  = (state_q == ST_PAD) ? '0 : in_data;
    assign pw_last  = (state_q == ST_ABSORB) && in_last;
    assign pw_final = (state_q == ST_PAD) ? wc_final : (wc_final && in_last);

    keccak_pad_word u_pad (
        .data     (pw_data),
        .nbytes   (in_nbytes),
        .last     (pw_last),
        .ds_in    (ds_pend_q),
        .is_final (pw_final),
        .word     (pw_word),
        .ds_pend  (pw_ds)
    );

    always_comb begin
        state_d     = state_q;
        wc_d        = wc_q;
        ds_pend_d   = ds_pend_q;
        msg_end_d   = msg_end_q;
        sipo_data_d = sipo_data;
        load_d      = 1'b0;
        last_d      = 1'b0;
        ps_d        = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            ST_ABSORB: begin
                if (in_valid) begin
                    load_d      = 1'b1;
                    sipo_data_d = pw_word;
                    if (in_last) begin
                        msg_end_d = 1'b1;
                        ds_pend_d = pw_ds;
                    end
                    if (wc_final) begin
                        last_d  = 1'b1;
                        state_d = ST_PSTART;
                    end else begin
                        wc_d = wc_q + 1'b1;
                        if (in_last)
                            state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                load_d      = 1'b1;
                sipo_data_d = pw_word;
                ds_pend_d   = 1'b0;
                if (wc_final) begin
                    last_d  = 1'b1;
                    state_d = ST_PSTART;
                end else begin
                    wc_d = wc_q + 1'b1;
                end
            end
            ST_PSTART: begin
                ps_d    = 1'b1;
                state_d = ST_PWAIT;
            end
            ST_PWAIT: begin
                if (perm_done) begin
                    wc_d = '0;
                    // a still-pending domain byte means a whole pad block is owed
                    if (ds_pend_q) begin
                        state_d = ST_PAD;
                    end else if (msg_end_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: state_d = ST_ABSORB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (hash_init) begin
            state_q      <= ST_ABSORB;
            wc_q         <= '0;
            ds_pend_q    <= 1'b0;
            msg_end_q    <= 1'b0;
            sipo_data    <= '0;
            sipo_load_en <= 1'b0;
            sipo_last    <= 1'b0;
            perm_start   <= 1'b0;
            msg_done     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wc_q         <= wc_d;
            ds_pend_q    <= ds_pend_d;
            msg_end_q    <= msg_end_d;
            sipo_data    <= sipo_data_d;
            sipo_load_en <= load_d;
            sipo_last    <= last_d;
            perm_start   <= ps_d;
            msg_done     <= done_d;
        end
    end

`ifdef KECCAK_BLKCNT_EN
    always_ff @(posedge clk) begin
        if (hash_init)
            blk_cnt <= '0;
        else if (state_q == ST_PSTART)
            blk_cnt <= blk_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// Scoreboard bench for keccak_absorb_ctrl: a byte-level pad10*1 model predicts
// every rate word; a monitor pops and compares on each sipo_load_en strobe.
module tb_keccak_absorb_ctrl;

    logic        clk = 1'b0;
    logic        hash_init = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_last = 1'b0;
    logic [3:0]  in_nbytes = '0;
    logic [63:0] sipo_data;
    logic        sipo_load_en, sipo_last, perm_start;
    logic        perm_done = 1'b0;
    logic        msg_done;
`ifdef KECCAK_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    always #5 clk = ~clk;

    keccak_absorb_ctrl dut (
        .clk          (clk),
        .hash_init    (hash_init),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_nbytes    (in_nbytes),
        .sipo_data    (sipo_data),
        .sipo_load_en (sipo_load_en),
        .sipo_last    (sipo_last),
        .perm_start   (perm_start),
        .perm_done    (perm_done),
        .msg_done     (msg_done)
`ifdef KECCAK_BLKCNT_EN
        ,
        .blk_cnt      (blk_cnt)
`endif
    );

    int          checks = 0;
    int          failures = 0;
    logic [64:0] sb[$];
    logic [63:0] msg [0:31];
    int          ps_count = 0;
    int          exp_perms = 0;
    int          perm_delay = 3;
    bit          auto_resp = 1'b1;
    int          stray_req = 0;
    int          stray_ack = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Byte-stream model: message bytes, 0x1F, zeros, last rate byte |= 0x80.
    task automatic expect_msg(input int n, input int nb);
        logic [7:0]  bbuf [0:503];
        logic [63:0] w;
        int len, total, nbe;
        nbe   = (nb > 8) ? 8 : nb;
        len   = 8 * (n - 1) + nbe;
        total = ((len + 1 + 167) / 168) * 168;
        for (int i = 0; i < total; i++) bbuf[i] = 8'h00;
        for (int i = 0; i < len; i++) begin
            w = msg[i / 8];
            bbuf[i] = w[8 * (i % 8) +: 8];
        end
        bbuf[len]       = 8'h1F;
        bbuf[total - 1] = bbuf[total - 1] | 8'h80;
        for (int k = 0; k < total / 8; k++) begin
            for (int b = 0; b < 8; b++) w[8 * b +: 8] = bbuf[8 * k + b];
            sb.push_back({(k % 21) == 20, w});
        end
        exp_perms = total / 168;
    endtask

    task automatic do_reset();
        @(negedge clk);
        hash_init = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        hash_init = 1'b0;
    endtask

    task automatic send_msg(input int n, input int nb, input bit gaps);
        int t, g;
        for (int w = 0; w < n; w++) begin
            if (gaps) begin
                in_valid = 1'b0;
                g = int'($urandom_range(1, 3));
                for (int j = 0; j < g; j++) begin
                    @(negedge clk);
                    check("gap_no_load", 64'(sipo_load_en), 64'd0);
                end
            end
            in_valid  = 1'b1;
            in_data   = msg[w];
            in_last   = (w == n - 1);
            in_nbytes = (w == n - 1) ? 4'(nb) : 4'd8;
            t = 0;
            while (!in_ready && t < 200) begin
                @(negedge clk);
                t++;
            end
            if (t >= 200) check("accept_timeout", 64'd1, 64'd0);
            @(posedge clk);
            @(negedge clk);
            check("load_latency", 64'(sipo_load_en), 64'd1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!msg_done && t < 3000) begin
            check("ready_low_after_last", 64'(in_ready), 64'd0);
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("msg_done_timeout", 64'd1, 64'd0);
        check("msg_done", 64'(msg_done), 64'd1);
        repeat (2) @(negedge clk);
        check("msg_done_hold", 64'(msg_done), 64'd1);
        check("done_ready", 64'(in_ready), 64'd0);
        check("done_no_load", 64'(sipo_load_en), 64'd0);
    endtask

    task automatic run_msg(input int n, input int nb, input bit gaps, input bit ones);
        int ps0;
        for (int i = 0; i < n; i++) msg[i] = ones ? '1 : {$urandom, $urandom};
        expect_msg(n, nb);
        ps0 = ps_count;
        send_msg(n, nb, gaps);
        wait_done();
        check("perm_count", 64'(ps_count - ps0), 64'(exp_perms));
        check("sb_drained", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: scoreboard compare plus perm_start pulse shape.
    initial begin
        logic [64:0] e;
        logic prev_ps = 1'b0, prev_last = 1'b0;
        forever begin
            @(negedge clk);
            if (sipo_load_en) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_load", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("sipo_data", sipo_data, e[63:0]);
                    check("sipo_last", 64'(sipo_last), 64'(e[64]));
                end
            end
            if (perm_start) begin
                check("ps_width", 64'(prev_ps), 64'd0);
                check("ps_after_last", 64'(prev_last), 64'd1);
                ps_count++;
            end
            prev_ps   = perm_start;
            prev_last = sipo_last;
        end
    end

    // Permutation core stand-in.
    initial begin
        forever begin
            @(negedge clk);
            if (stray_req != stray_ack) begin
                perm_done = 1'b1;
                @(negedge clk);
                perm_done = 1'b0;
                stray_ack = stray_req;
            end else if (perm_start && auto_resp) begin
                for (int d = 0; d < perm_delay; d++) begin
                    @(negedge clk);
                    check("pwait_ready", 64'(in_ready), 64'd0);
                    check("pwait_no_load", 64'(sipo_load_en), 64'd0);
                end
                perm_done = 1'b1;
                @(negedge clk);
                perm_done = 1'b0;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ps0, t;
        do_reset();
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_load", 64'(sipo_load_en), 64'd0);
        check("rst_last", 64'(sipo_last), 64'd0);
        check("rst_pstart", 64'(perm_start), 64'd0);
        check("rst_done", 64'(msg_done), 64'd0);
        check("rst_data", sipo_data, 64'd0);

        // 1: empty message
        run_msg(1, 0, 1'b0, 1'b0);

        // 2: 21 full words, extra pad block
        do_reset();
        run_msg(21, 8, 1'b0, 1'b0);
`ifdef KECCAK_BLKCNT_EN
        check("blk_cnt", 64'(blk_cnt), 64'd2);
`endif

        // 3: final word nbytes=7 -> byte7 = 0x9F
        do_reset();
        run_msg(21, 7, 1'b0, 1'b0);

        // 4: gapped input, all-ones data, nbytes=3
        do_reset();
        run_msg(3, 3, 1'b1, 1'b1);

        // 6: slow permutation, nbytes>8 clamps to 8
        do_reset();
        perm_delay = 50;
        run_msg(5, 12, 1'b0, 1'b0);
        perm_delay = 3;

        // 5: hash_init during PWAIT, stray perm_done afterwards
        do_reset();
        auto_resp = 1'b0;
        msg[0] = {$urandom, $urandom};
        expect_msg(1, 0);
        ps0 = ps_count;
        send_msg(1, 0, 1'b0);
        t = 0;
        while (ps_count == ps0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t5_perm_started", 64'(ps_count - ps0), 64'd1);
        repeat (5) @(negedge clk);
        do_reset();
        stray_req++;
        repeat (4) @(negedge clk);
        check("t5_ready", 64'(in_ready), 64'd1);
        check("t5_done", 64'(msg_done), 64'd0);
        check("t5_no_load", 64'(sipo_load_en), 64'd0);
        check("t5_no_pstart", 64'(perm_start), 64'd0);
        check("t5_sb_empty", 64'(sb.size()), 64'd0);
        auto_resp = 1'b1;
        run_msg(1, 0, 1'b0, 1'b0);
`ifdef KECCAK_BLKCNT_EN
        check("t5_blk_cnt", 64'(blk_cnt), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
